// File: rtl/pdp_rd_dma_arb.sv
// PDP read-DMA arbiter.
// Shares one MCIF read request/response channel between two PDP read clients
// (req0 = RDMA, req1 = auxiliary line fetch). Requests are granted round-robin
// only while latency-FIFO credits cover their beats. Grant order is recorded
// so that in-order responses can be steered back to their owner. Every
// consumed response beat returns one credit through the lat-FIFO pop strobe.
module pdp_rd_dma_arb #(
    parameter int CREDITS   = 64,
    parameter int ORD_DEPTH = 8,
    parameter int CNT_W     = 7
) (
    input  logic         nvdla_core_clk,
    input  logic         nvdla_core_rstn,

    input  logic         req0_valid,
    output logic         req0_ready,
    input  logic [78:0]  req0_pd,
    input  logic         req1_valid,
    output logic         req1_ready,
    input  logic [78:0]  req1_pd,

    output logic         rsp0_valid,
    input  logic         rsp0_ready,
    output logic [256:0] rsp0_pd,
    output logic         rsp1_valid,
    input  logic         rsp1_ready,
    output logic [256:0] rsp1_pd,

    output logic         pdp2mcif_rd_req_valid,
    input  logic         pdp2mcif_rd_req_ready,
    output logic [78:0]  pdp2mcif_rd_req_pd,

    input  logic         mcif2pdp_rd_rsp_valid,
    output logic         mcif2pdp_rd_rsp_ready,
    input  logic [256:0] mcif2pdp_rd_rsp_pd,

    output logic         pdp2mcif_rd_cdt_lat_fifo_pop,
    output logic         arb_idle,
    output logic         err_unexp_rsp
);

    localparam int PTR_W  = (ORD_DEPTH > 1) ? $clog2(ORD_DEPTH) : 1;
    localparam int OCNT_W = $clog2(ORD_DEPTH + 1);

    // Registered state
    logic [CNT_W-1:0]  r_reserved;
    logic [PTR_W-1:0]  r_wr_ptr;
    logic [PTR_W-1:0]  r_rd_ptr;
    logic [OCNT_W-1:0] r_ord_cnt;
    logic              r_ord_id   [ORD_DEPTH];
    logic [14:0]       r_ord_size [ORD_DEPTH];
    logic [14:0]       r_beat_cnt;
    logic              r_rr_last;      // 1: requester 1 was granted last
    logic              r_out_valid;
    logic [78:0]       r_out_pd;
    logic              r_pop;
    logic              r_err;

    // Combinational nets
    logic              w_ord_empty;
    logic              w_ord_full;
    logic              w_drain;
    logic              w_slot_ok;
    logic [31:0]       w_free;
    logic [31:0]       w_beats0;
    logic [31:0]       w_beats1;
    logic              w_elig0;
    logic              w_elig1;
    logic              w_grant0;
    logic              w_grant1;
    logic              w_grant;
    logic [78:0]       w_grant_pd;
    logic [14:0]       w_grant_size;
    logic [CNT_W-1:0]  w_grant_beats;
    logic [CNT_W-1:0]  w_reserved_nxt;
    logic              w_head_id;
    logic [14:0]       w_head_size;
    logic              w_rsp_ready;
    logic              w_rsp_hs;
    logic              w_last_beat;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(ORD_DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    // Eligibility: enough free credits, a free order entry (judged at cycle
    // start, so a same-cycle pop never makes room), and an empty or draining
    // output slot.
    assign w_ord_empty = (r_ord_cnt == '0);
    assign w_ord_full  = (r_ord_cnt == OCNT_W'(ORD_DEPTH));
    assign w_drain     = r_out_valid & pdp2mcif_rd_req_ready;
    assign w_slot_ok   = ~r_out_valid | w_drain;
    assign w_free      = 32'(CREDITS) - 32'(r_reserved);
    assign w_beats0    = 32'(req0_pd[78:64]) + 32'd1;
    assign w_beats1    = 32'(req1_pd[78:64]) + 32'd1;
    assign w_elig0     = req0_valid & (w_beats0 <= w_free) & ~w_ord_full & w_slot_ok;
    assign w_elig1     = req1_valid & (w_beats1 <= w_free) & ~w_ord_full & w_slot_ok;

    // Round-robin pick between eligible requesters and the granted payload.
    // NOTE: every output of this block gets a default first so no latch is inferred.
    always_comb begin
        w_grant0      = 1'b0;
        w_grant1      = 1'b0;
        w_grant_pd    = req0_pd;
        w_grant_size  = req0_pd[78:64];
        w_grant_beats = '0;
        if (w_elig0 && w_elig1) begin
            if (r_rr_last) w_grant0 = 1'b1;
            else           w_grant1 = 1'b1;
        end else begin
            w_grant0 = w_elig0;
            w_grant1 = w_elig1;
        end
        if (w_grant1) begin
            w_grant_pd   = req1_pd;
            w_grant_size = req1_pd[78:64];
        end
        if (w_grant0 || w_grant1) begin
            // A granted size is below CREDITS, so it fits the credit counter.
            w_grant_beats = CNT_W'(w_grant_size) + CNT_W'(1);
        end
    end

    assign w_grant        = w_grant0 | w_grant1;
    assign req0_ready     = w_grant0;
    assign req1_ready     = w_grant1;
    // Credits released by last cycle's pop pulse and reserved by this grant net out.
    assign w_reserved_nxt = r_reserved + w_grant_beats - CNT_W'(r_pop);

    // Response steering from the head of the order FIFO; purely combinational.
    assign w_head_id             = r_ord_id[r_rd_ptr];
    assign w_head_size           = r_ord_size[r_rd_ptr];
    assign w_rsp_ready           = ~w_ord_empty & (w_head_id ? rsp1_ready : rsp0_ready);
    assign w_rsp_hs              = mcif2pdp_rd_rsp_valid & w_rsp_ready;
    assign w_last_beat           = w_rsp_hs & (r_beat_cnt == w_head_size);
    assign mcif2pdp_rd_rsp_ready = w_rsp_ready;
    assign rsp0_valid            = mcif2pdp_rd_rsp_valid & ~w_ord_empty & ~w_head_id;
    assign rsp1_valid            = mcif2pdp_rd_rsp_valid & ~w_ord_empty &  w_head_id;
    assign rsp0_pd               = mcif2pdp_rd_rsp_pd;
    assign rsp1_pd               = mcif2pdp_rd_rsp_pd;

    assign pdp2mcif_rd_req_valid        = r_out_valid;
    assign pdp2mcif_rd_req_pd           = r_out_pd;
    assign pdp2mcif_rd_cdt_lat_fifo_pop = r_pop;
    assign err_unexp_rsp                = r_err;
    assign arb_idle = w_ord_empty & ~r_out_valid & (r_reserved == '0) & ~r_pop;

    // Order FIFO payload: {id, size} written at the tail on every grant.
    // NOTE: payload storage has no reset; pointers and count do, so stale entries are never read.
    always_ff @(posedge nvdla_core_clk) begin
        if (w_grant) begin
            r_ord_id[r_wr_ptr]   <= w_grant1;
            r_ord_size[r_wr_ptr] <= w_grant_size;
        end
    end

    // Control state: credits, FIFO pointers, beat counter, RR pointer, output slot, pop, error.
    // NOTE: non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge nvdla_core_clk) begin
        if (!nvdla_core_rstn) begin
            r_reserved  <= '0;
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
            r_ord_cnt   <= '0;
            r_beat_cnt  <= '0;
            r_rr_last   <= 1'b1;
            r_out_valid <= 1'b0;
            r_out_pd    <= '0;
            r_pop       <= 1'b0;
            r_err       <= 1'b0;
        end else begin
            r_reserved <= w_reserved_nxt;
            r_pop      <= w_rsp_hs;
            r_err      <= r_err | (mcif2pdp_rd_rsp_valid & w_ord_empty);
            r_ord_cnt  <= r_ord_cnt + OCNT_W'(w_grant) - OCNT_W'(w_last_beat);

            if (w_grant) begin
                r_wr_ptr    <= ptr_inc(r_wr_ptr);
                r_rr_last   <= w_grant1;
                r_out_valid <= 1'b1;
                r_out_pd    <= w_grant_pd;
            end else if (w_drain) begin
                r_out_valid <= 1'b0;
            end

            if (w_rsp_hs) begin
                if (w_last_beat) begin
                    r_beat_cnt <= '0;
                    r_rd_ptr   <= ptr_inc(r_rd_ptr);
                end else begin
                    r_beat_cnt <= r_beat_cnt + 15'd1;
                end
            end
        end
    end

endmodule

// File: tb/tb_pdp_rd_dma_arb.sv
// Self-checking bench for pdp_rd_dma_arb: a cycle table from reset, hand
// sequences for multi-cycle corners, then random traffic against a queue model.
module tb_pdp_rd_dma_arb;

    localparam int CREDITS = 64;

    logic         clk = 1'b0;
    logic         rstn;
    logic         req0_valid, req0_ready, req1_valid, req1_ready;
    logic [78:0]  req0_pd, req1_pd;
    logic         rsp0_valid, rsp0_ready, rsp1_valid, rsp1_ready;
    logic [256:0] rsp0_pd, rsp1_pd;
    logic         mreq_valid, mreq_ready;
    logic [78:0]  mreq_pd;
    logic         mrsp_valid, mrsp_ready;
    logic [256:0] mrsp_pd;
    logic         cdt_pop, arb_idle, err_unexp;

    always #5 clk = ~clk;

    pdp_rd_dma_arb #(.CREDITS(CREDITS), .ORD_DEPTH(8), .CNT_W(7)) dut (
        .nvdla_core_clk               (clk),
        .nvdla_core_rstn              (rstn),
        .req0_valid                   (req0_valid),
        .req0_ready                   (req0_ready),
        .req0_pd                      (req0_pd),
        .req1_valid                   (req1_valid),
        .req1_ready                   (req1_ready),
        .req1_pd                      (req1_pd),
        .rsp0_valid                   (rsp0_valid),
        .rsp0_ready                   (rsp0_ready),
        .rsp0_pd                      (rsp0_pd),
        .rsp1_valid                   (rsp1_valid),
        .rsp1_ready                   (rsp1_ready),
        .rsp1_pd                      (rsp1_pd),
        .pdp2mcif_rd_req_valid        (mreq_valid),
        .pdp2mcif_rd_req_ready        (mreq_ready),
        .pdp2mcif_rd_req_pd           (mreq_pd),
        .mcif2pdp_rd_rsp_valid        (mrsp_valid),
        .mcif2pdp_rd_rsp_ready        (mrsp_ready),
        .mcif2pdp_rd_rsp_pd           (mrsp_pd),
        .pdp2mcif_rd_cdt_lat_fifo_pop (cdt_pop),
        .arb_idle                     (arb_idle),
        .err_unexp_rsp                (err_unexp)
    );

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check_bit(input string name, input logic act, input logic exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %b expected %b (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic check_vec(input string name, input logic [256:0] act, input logic [256:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [78:0] mk_pd(input logic [14:0] sz, input logic [63:0] addr);
        return {sz, addr};
    endfunction

    function automatic logic [256:0] rnd_beat();
        return {$urandom(), $urandom(), $urandom(), $urandom(),
                $urandom(), $urandom(), $urandom(), $urandom(), 1'($urandom())};
    endfunction

    task automatic idle_inputs();
        req0_valid = 1'b0; req0_pd = '0;
        req1_valid = 1'b0; req1_pd = '0;
        mreq_ready = 1'b1;
        mrsp_valid = 1'b0; mrsp_pd = '0;
        rsp0_ready = 1'b1; rsp1_ready = 1'b1;
    endtask

    task automatic do_reset();
        rstn = 1'b0;
        idle_inputs();
        repeat (2) @(posedge clk);
        @(negedge clk);
        rstn = 1'b1;
    endtask

    // Feed n response beats with both requesters ready; every beat must be taken.
    task automatic drain(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            req0_valid = 1'b0; req1_valid = 1'b0;
            mrsp_valid = 1'b1; mrsp_pd = rnd_beat();
            rsp0_ready = 1'b1; rsp1_ready = 1'b1;
            #1;
            check_bit("drain_rsp_ready", mrsp_ready, 1'b1);
        end
        @(negedge clk);
        mrsp_valid = 1'b0;
    endtask

    task automatic wait_idle(input string name, input int bound);
        for (int i = 0; i < bound; i++) begin
            #1;
            if (arb_idle) break;
            @(negedge clk);
        end
        check_bit(name, arb_idle, 1'b1);
    endtask

    // Cycle table: inputs and expected {req0_ready, req1_ready, req_valid,
    // rsp_ready, rsp0_valid, rsp1_valid, cdt_pop, arb_idle}.
    typedef struct {
        logic        r0v;
        logic [14:0] r0s;
        logic        r1v;
        logic [14:0] r1s;
        logic        mrdy;
        logic        rv;
        logic        rr0;
        logic        rr1;
        logic [7:0]  exp;
    } vec_t;

    function automatic vec_t mkv(input int a, input int s0, input int b, input int s1,
                                 input int mr, input int rv, input int r0, input int r1,
                                 input logic [7:0] e);
        vec_t v;
        v.r0v = 1'(a);  v.r0s = 15'(s0);
        v.r1v = 1'(b);  v.r1s = 15'(s1);
        v.mrdy = 1'(mr); v.rv = 1'(rv);
        v.rr0 = 1'(r0); v.rr1 = 1'(r1);
        v.exp = e;
        return v;
    endfunction

    // Reference model for the random phase: outstanding requests as a queue
    // of {owner, beats still due}, credits as a plain integer.
    typedef struct { bit id; int rem; } ent_t;
    ent_t        m_q[$];
    int          m_res;
    bit          m_pop, m_slot, m_last;
    logic [78:0] m_slot_pd;

    string fld[8] = '{"req0_ready", "req1_ready", "req_valid", "rsp_ready",
                      "rsp0_valid", "rsp1_valid", "cdt_pop", "arb_idle"};

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish (t=%0t)", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t        vt[16];
        logic [7:0]  act;
        logic [78:0] pd_a, pd_b;

        vt[0]  = mkv(1, 3, 0, 0, 1, 0, 1, 1, 8'b1000_0001);
        vt[1]  = mkv(0, 0, 0, 0, 1, 0, 1, 1, 8'b0011_0000);
        vt[2]  = mkv(0, 0, 0, 0, 1, 1, 1, 1, 8'b0001_1000);
        vt[3]  = mkv(0, 0, 0, 0, 1, 1, 1, 1, 8'b0001_1010);
        vt[4]  = mkv(0, 0, 0, 0, 1, 1, 1, 1, 8'b0001_1010);
        vt[5]  = mkv(0, 0, 0, 0, 1, 1, 1, 1, 8'b0001_1010);
        vt[6]  = mkv(0, 0, 0, 0, 1, 0, 1, 1, 8'b0000_0010);
        vt[7]  = mkv(0, 0, 0, 0, 1, 0, 1, 1, 8'b0000_0001);
        vt[8]  = mkv(1, 0, 1, 0, 1, 0, 1, 1, 8'b0100_0001);
        vt[9]  = mkv(1, 0, 1, 0, 1, 0, 1, 1, 8'b1011_0000);
        vt[10] = mkv(1, 0, 1, 0, 1, 1, 1, 1, 8'b0111_0100);
        vt[11] = mkv(0, 0, 0, 0, 1, 1, 1, 1, 8'b0011_1010);
        vt[12] = mkv(0, 0, 0, 0, 1, 1, 1, 0, 8'b0000_0110);
        vt[13] = mkv(0, 0, 0, 0, 1, 1, 1, 1, 8'b0001_0100);
        vt[14] = mkv(0, 0, 0, 0, 1, 0, 1, 1, 8'b0000_0010);
        vt[15] = mkv(0, 0, 0, 0, 1, 0, 1, 1, 8'b0000_0001);

        do_reset();

        // Reset state
        @(negedge clk); #1;
        check_bit("rst_req_valid", mreq_valid, 1'b0);
        check_vec("rst_req_pd", 257'(mreq_pd), '0);
        check_bit("rst_pop", cdt_pop, 1'b0);
        check_bit("rst_err", err_unexp, 1'b0);
        check_bit("rst_idle", arb_idle, 1'b1);

        // Single 4-beat request, then both requesters contending
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            req0_valid = vt[i].r0v; req0_pd = mk_pd(vt[i].r0s, 64'h1000 + 64'(i * 64));
            req1_valid = vt[i].r1v; req1_pd = mk_pd(vt[i].r1s, 64'h8000 + 64'(i * 64));
            mreq_ready = vt[i].mrdy;
            mrsp_valid = vt[i].rv; mrsp_pd = rnd_beat();
            rsp0_ready = vt[i].rr0; rsp1_ready = vt[i].rr1;
            #1;
            act = {req0_ready, req1_ready, mreq_valid, mrsp_ready,
                   rsp0_valid, rsp1_valid, cdt_pop, arb_idle};
            for (int j = 0; j < 8; j++)
                check_bit($sformatf("vec%0d_%s", i, fld[j]), act[7-j], vt[i].exp[7-j]);
            if (i == 1) check_vec("vec1_req_pd", 257'(mreq_pd), 257'(mk_pd(15'd3, 64'h1000)));
        end

        // Credit stall: a 64-beat request exhausts credits until one is returned
        @(negedge clk);
        idle_inputs();
        req0_valid = 1'b1; req0_pd = mk_pd(15'd63, 64'h5000);
        #1;
        check_bit("stall_grant_big", req0_ready, 1'b1);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            req0_valid = 1'b0;
            req1_valid = 1'b1; req1_pd = mk_pd(15'd0, 64'h6000);
            #1;
            check_bit("stall_no_credit", req1_ready, 1'b0);
        end
        @(negedge clk);
        mrsp_valid = 1'b1; mrsp_pd = rnd_beat();
        #1;
        check_bit("stall_first_beat", rsp0_valid, 1'b1);
        check_bit("stall_still_full", req1_ready, 1'b0);
        @(negedge clk);
        mrsp_valid = 1'b0;
        #1;
        check_bit("stall_pop", cdt_pop, 1'b1);
        check_bit("stall_during_pop", req1_ready, 1'b0);
        @(negedge clk); #1;
        check_bit("stall_grant_after_pop", req1_ready, 1'b1);
        drain(64);
        wait_idle("stall_idle", 50);

        // Output backpressure, then response backpressure mid-burst
        pd_a = mk_pd(15'd1, 64'h2000);
        pd_b = mk_pd(15'd0, 64'h3000);
        @(negedge clk);
        idle_inputs();
        req0_valid = 1'b1; req0_pd = pd_a; mreq_ready = 1'b0;
        #1;
        check_bit("bp_grant_a", req0_ready, 1'b1);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            req0_valid = 1'b0;
            req1_valid = 1'b1; req1_pd = pd_b; mreq_ready = 1'b0;
            #1;
            check_bit("bp_hold_valid", mreq_valid, 1'b1);
            check_vec("bp_hold_pd", 257'(mreq_pd), 257'(pd_a));
            check_bit("bp_no_grant", req1_ready, 1'b0);
        end
        @(negedge clk);
        mreq_ready = 1'b1;
        #1;
        check_bit("bp_drain_grant", req1_ready, 1'b1);
        check_vec("bp_drain_pd", 257'(mreq_pd), 257'(pd_a));
        @(negedge clk);
        req1_valid = 1'b0; mreq_ready = 1'b0;
        #1;
        check_bit("bp_b_valid", mreq_valid, 1'b1);
        check_vec("bp_b_pd", 257'(mreq_pd), 257'(pd_b));
        @(negedge clk);
        mreq_ready = 1'b1; mrsp_valid = 1'b1; mrsp_pd = rnd_beat(); rsp0_ready = 1'b1;
        #1;
        check_bit("bp_beat0_valid", rsp0_valid, 1'b1);
        check_bit("bp_beat0_ready", mrsp_ready, 1'b1);
        check_vec("bp_beat0_pd", rsp0_pd, mrsp_pd);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            rsp0_ready = 1'b0;
            #1;
            check_bit("bp_rsp_held_ready", mrsp_ready, 1'b0);
            check_bit("bp_rsp_held_valid", rsp0_valid, 1'b1);
            check_bit("bp_rsp_held_pop", cdt_pop, i == 0);
        end
        @(negedge clk);
        rsp0_ready = 1'b1;
        #1;
        check_bit("bp_beat1_ready", mrsp_ready, 1'b1);
        @(negedge clk);
        mrsp_pd = rnd_beat();
        #1;
        check_bit("bp_b_rsp1_valid", rsp1_valid, 1'b1);
        check_bit("bp_b_rsp0_quiet", rsp0_valid, 1'b0);
        check_bit("bp_b_pop", cdt_pop, 1'b1);
        @(negedge clk);
        mrsp_valid = 1'b0;
        wait_idle("bp_idle", 20);

        // Order FIFO full: eight grants, ninth held, no pass-through on pop
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            idle_inputs();
            req0_valid = 1'b1; req0_pd = mk_pd(15'd0, 64'h4000 + 64'(i * 32));
            #1;
            check_bit($sformatf("full_grant%0d", i), req0_ready, i < 8);
        end
        @(negedge clk);
        mrsp_valid = 1'b1; mrsp_pd = rnd_beat();
        #1;
        check_bit("full_no_passthru", req0_ready, 1'b0);
        check_bit("full_rsp_ready", mrsp_ready, 1'b1);
        @(negedge clk);
        mrsp_valid = 1'b0;
        #1;
        check_bit("full_refill", req0_ready, 1'b1);
        drain(8);
        wait_idle("full_idle", 20);

        // Unexpected response while idle
        @(negedge clk);
        idle_inputs();
        mrsp_valid = 1'b1; mrsp_pd = rnd_beat();
        #1;
        check_bit("err_rsp_ready", mrsp_ready, 1'b0);
        check_bit("err_rsp0_valid", rsp0_valid, 1'b0);
        check_bit("err_rsp1_valid", rsp1_valid, 1'b0);
        check_bit("err_not_yet", err_unexp, 1'b0);
        @(negedge clk);
        mrsp_valid = 1'b0;
        #1;
        check_bit("err_set", err_unexp, 1'b1);
        @(negedge clk); #1;
        check_bit("err_sticky", err_unexp, 1'b1);

        // Reset in the middle of a burst
        @(negedge clk);
        req0_valid = 1'b1; req0_pd = mk_pd(15'd3, 64'h7000);
        #1;
        check_bit("mid_grant", req0_ready, 1'b1);
        @(negedge clk);
        req0_valid = 1'b0; mrsp_valid = 1'b1; mrsp_pd = rnd_beat();
        #1;
        check_bit("mid_beat0", rsp0_valid, 1'b1);
        @(negedge clk);
        rstn = 1'b0;
        @(negedge clk);
        idle_inputs();
        #1;
        check_bit("mid_rst_req_valid", mreq_valid, 1'b0);
        check_vec("mid_rst_req_pd", 257'(mreq_pd), '0);
        check_bit("mid_rst_pop", cdt_pop, 1'b0);
        check_bit("mid_rst_err", err_unexp, 1'b0);
        check_bit("mid_rst_idle", arb_idle, 1'b1);

        // Random traffic against the queue model
        do_reset();
        m_q.delete();
        m_res = 0; m_pop = 0; m_slot = 0; m_last = 1; m_slot_pd = '0;
        for (int cyc = 0; cyc < 1500; cyc++) begin
            logic [14:0] sz0, sz1;
            bit   drain_now, room, e0, e1, g0, g1, nonempty, hid, x_v0, x_v1, x_mrr, hs;
            int   b0, b1;
            @(negedge clk);
            sz0 = ($urandom_range(0, 3) == 0) ? 15'($urandom_range(0, 40)) : 15'($urandom_range(0, 3));
            sz1 = ($urandom_range(0, 3) == 0) ? 15'($urandom_range(0, 40)) : 15'($urandom_range(0, 3));
            req0_valid = 1'($urandom_range(0, 1)); req0_pd = mk_pd(sz0, {$urandom(), $urandom()});
            req1_valid = 1'($urandom_range(0, 1)); req1_pd = mk_pd(sz1, {$urandom(), $urandom()});
            mreq_ready = ($urandom_range(0, 3) != 0);
            mrsp_valid = (m_q.size() != 0) && ($urandom_range(0, 2) != 0);
            mrsp_pd    = rnd_beat();
            rsp0_ready = ($urandom_range(0, 3) != 0);
            rsp1_ready = ($urandom_range(0, 3) != 0);
            #1;

            b0 = int'(sz0) + 1;
            b1 = int'(sz1) + 1;
            drain_now = m_slot && mreq_ready;
            room = (m_q.size() < 8) && (!m_slot || drain_now);
            e0 = req0_valid && room && (b0 <= CREDITS - m_res);
            e1 = req1_valid && room && (b1 <= CREDITS - m_res);
            g0 = e0 && (!e1 || m_last);
            g1 = e1 && (!e0 || !m_last);
            nonempty = (m_q.size() != 0);
            hid   = nonempty ? m_q[0].id : 1'b0;
            x_v0  = mrsp_valid && nonempty && !hid;
            x_v1  = mrsp_valid && nonempty && hid;
            x_mrr = nonempty && (hid ? rsp1_ready : rsp0_ready);
            hs    = mrsp_valid && x_mrr;

            check_bit("rnd_req0_ready", req0_ready, g0);
            check_bit("rnd_req1_ready", req1_ready, g1);
            check_bit("rnd_req_valid", mreq_valid, m_slot);
            if (m_slot) check_vec("rnd_req_pd", 257'(mreq_pd), 257'(m_slot_pd));
            check_bit("rnd_rsp_ready", mrsp_ready, x_mrr);
            check_bit("rnd_rsp0_valid", rsp0_valid, x_v0);
            check_bit("rnd_rsp1_valid", rsp1_valid, x_v1);
            if (x_v0) check_vec("rnd_rsp0_pd", rsp0_pd, mrsp_pd);
            if (x_v1) check_vec("rnd_rsp1_pd", rsp1_pd, mrsp_pd);
            check_bit("rnd_pop", cdt_pop, m_pop);
            check_bit("rnd_idle", arb_idle, !nonempty && !m_slot && m_res == 0 && !m_pop);
            check_bit("rnd_err", err_unexp, 1'b0);

            m_res = m_res + (g0 ? b0 : 0) + (g1 ? b1 : 0) - (m_pop ? 1 : 0);
            m_pop = hs;
            if (hs) begin
                m_q[0].rem--;
                if (m_q[0].rem == 0) void'(m_q.pop_front());
            end
            if (g0 || g1) begin
                m_q.push_back('{id: g1, rem: g1 ? b1 : b0});
                m_slot    = 1;
                m_slot_pd = g1 ? req1_pd : req0_pd;
                m_last    = g1;
            end else if (drain_now) begin
                m_slot = 0;
            end
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
